cfu_simd_mac: RTL and testbench
===============================

Name: cfu_simd_mac

Overview:
4-lane int8 SIMD multiply-accumulate stage. It sits directly upstream of the CFU register block: it consumes the packed input and filter words from the CFU operand bus, plus the current input offset from that register block. It produces one 32-bit signed dot-product partial per accepted beat, and each result drives the register block's accumulate-add strobe and value. The block is a 3-stage pipeline with valid/ready handshakes and a beat counter.

Parameters:
LANES, 4, number of int8 lanes packed in each 32-bit operand; fixed at 4 in this revision, any other value is rejected at elaboration.
OFF_W, 9, number of low bits of the offset used as a signed per-lane offset.
CNT_W, 16, width of the beat counter.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset_n  in  1  synchronous active-low reset.
in_valid  in  1  operand beat valid.
in_ready  out  1  block can accept a beat this cycle.
in_data  in  32  packed signed int8 activations; lane i = bits[8i+7:8i].
in_filter  in  32  packed signed int8 weights, same lane layout.
in_offset  in  32  signed input offset from the register block; only bits[OFF_W-1:0] are used.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts the result; the integrator ties this high when the register block is used directly.
out_value  out  32  signed dot-product result.
out_add_acc  out  1  equals out_valid && out_ready; drives the accumulate-add flag downstream.
cnt_clear  in  1  clears the beat counter.
beat_count  out  CNT_W  number of results transferred since reset or the last clear.

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - All stage valids go to 0, so out_valid=0 and out_add_acc=0.
  - out_value=0 and beat_count=0.
  - in_ready is 1 in the first cycle after reset.
  - Reset has priority over every other input. Reset in mid-operation discards all in-flight beats; no partial result is emitted.
- Pipeline advance:
  - en = !out_valid || out_ready, and in_ready = en.
  - The whole pipeline shifts only when en=1; when en=0 every stage register holds, including out_value and out_valid.
- Acceptance:
  - A beat is accepted when in_valid && in_ready.
  - in_offset is sampled in the same cycle as in_data and in_filter. Later changes to the offset do not affect beats already in flight.
- S1 (capture):
  - Per lane, a_i = sext(in_data lane i) + sext(in_offset[OFF_W-1:0]), computed as a 10-bit signed value.
  - The filter byte f_i is registered alongside a_i.
  - s1_valid takes the acceptance value.
- S2 (multiply):
  - p_i = a_i * f_i, 18-bit signed; this cannot overflow.
  - s2_valid <= s1_valid.
- S3 (reduce):
  - sum = p0+p1+p2+p3, 20-bit signed, sign-extended to 32 bits into out_value.
  - out_valid <= s2_valid.
- Latency and throughput:
  - A beat accepted in cycle N appears as out_valid in cycle N+3, with no stalls.
  - Throughput is one result per cycle.
- Bubbles: a bubble (stage valid = 0) still moves forward when en=1. out_value is don't-care while out_valid=0, and the bench must not check it then.
- Backpressure:
  - With out_ready=0 and out_valid=1, at most 3 beats are held, one per stage.
  - in_ready stays 0 until the result transfers; no beat is dropped or duplicated.
- Counter:
  - On out_valid && out_ready, beat_count increments, wrapping modulo 2^CNT_W.
  - cnt_clear takes priority over an increment in the same cycle, so the result is 0, not 1.
- No arithmetic saturation is performed anywhere in the block; the datapath widths are exact.

Decomposition:
- Shared package cfu_mac_pkg holds:
  - constants LANES=4, LANE_W=8, OFF_W=9, PROD_W=18, SUM_W=20;
  - a lane-extract function returning the signed byte i of a 32-bit word.
- One natural sub-module, cfu_mac_lane: the per-lane S1/S2 registers (offset add, multiply) with an enable input. It is instantiated LANES times.
- The reduction stage, the handshake logic and the counter stay in the top module.

Test Plan:
- Basic dot product: in_data=0x7F80FF01, in_filter=0xFF040302, in_offset=128, out_ready=1.
  - Lanes are 1/-1/-128/127 with offset 128, giving 129/127/0/255, against filters 2/3/4/-1.
  - Required: out_value=384 (0x00000180) with out_valid and out_add_acc high exactly 3 cycles after acceptance; beat_count=1.
- Worst-case negative: in_data=0x7F7F7F7F, in_filter=0x80808080, in_offset=255.
  - Required: out_value=0xFFFD0400 (-195584).
- Offset truncation: in_offset=0x00000180, so the low 9 bits are -128.
  - With in_data=0x00000080 and in_filter=0x00000001, lane 0 gives -256 and the other lanes give -128*0=0.
  - Required: out_value=-256 (0xFFFFFF00).
- Backpressure: stream 5 back-to-back beats with in_valid=1 and hold out_ready=0 from cycle 3 to cycle 7.
  - Required: in_ready=0 while stalled.
  - All 5 results emerge in order with no loss or duplication, and beat_count=5.
- Reset mid-stream: issue 2 beats, then pull reset_n=0 for 1 cycle one cycle before the first result.
  - Required: no out_valid afterwards, beat_count=0, in_ready=1 after release.
- Counter boundary: preload via 65535 transfers (or force), then transfer one more beat.
  - Required: beat_count wraps to 0.
  - Separately, cnt_clear asserted together with a transfer leaves beat_count=0.

Source files
------------

// File: rtl/cfu_simd_mac_pkg.sv
// Shared constants and helpers for the CFU SIMD multiply-accumulate stage.
package cfu_mac_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 8;
  localparam int unsigned OFF_W  = 9;
  localparam int unsigned PROD_W = 18;
  localparam int unsigned SUM_W  = 20;

  // Signed byte idx of a packed 32-bit operand word.
  function automatic logic signed [LANE_W-1:0] lane_byte(input logic [31:0] word,
                                                         input int unsigned idx);
    return word[LANE_W*idx +: LANE_W];
  endfunction

endpackage

// File: rtl/cfu_simd_mac_if.sv
// Operand/result bus between the CFU operand path, the MAC stage and the register block.
interface cfu_simd_mac_if #(
  parameter int unsigned CNT_W = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic [31:0]      in_filter;
  logic [31:0]      in_offset;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_value;
  logic             out_add_acc;
  logic             cnt_clear;
  logic [CNT_W-1:0] beat_count;

  modport master (
    output in_valid, in_data, in_filter, in_offset, out_ready, cnt_clear,
    input  in_ready, out_valid, out_value, out_add_acc, beat_count
  );

  modport slave (
    input  in_valid, in_data, in_filter, in_offset, out_ready, cnt_clear,
    output in_ready, out_valid, out_value, out_add_acc, beat_count
  );

endinterface

// File: rtl/cfu_simd_mac_lane.sv
// One int8 lane: S1 offset add with filter capture, S2 signed multiply.
module cfu_mac_lane
  import cfu_mac_pkg::*;
#(
  parameter int unsigned  OffW  = OFF_W,
  localparam int unsigned AddW  = ((OffW > LANE_W) ? OffW : LANE_W) + 1,
  localparam int unsigned ProdW = AddW + LANE_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic signed [LANE_W-1:0] act,
  input  logic signed [LANE_W-1:0] filt,
  input  logic signed [OffW-1:0]   offset,
  output logic signed [ProdW-1:0]  prod
);

  logic signed [AddW-1:0]   a_d, a_q;
  logic signed [LANE_W-1:0] f_q;
  logic signed [ProdW-1:0]  p_d, p_q;

  // Exact-width arithmetic: sign-extended operands, products cannot overflow.
  always_comb begin
    a_d = AddW'(act) + AddW'(offset);
    p_d = ProdW'(a_q) * ProdW'(f_q);
  end

  // Stage registers hold while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_q <= '0;
      f_q <= '0;
      p_q <= '0;
    end else if (en) begin
      a_q <= a_d;
      f_q <= filt;
      p_q <= p_d;
    end
  end

  assign prod = p_q;

endmodule

// File: rtl/cfu_simd_mac.sv
// 4-lane int8 SIMD dot-product stage: 3-stage pipeline, valid/ready, beat counter.
module cfu_simd_mac
  import cfu_mac_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned OFF_W = 9,
  parameter int unsigned CNT_W = 16
) (
  input logic           clk,
  input logic           reset_n,
  cfu_simd_mac_if.slave bus
);

  localparam int unsigned ProdW = ((OFF_W > LANE_W) ? OFF_W : LANE_W) + 1 + LANE_W;
  localparam int unsigned SumW  = ProdW + 2;

  if (LANES != 4) begin : g_lanes_check
    $error("cfu_simd_mac: LANES must be 4");
  end

  logic                    en;
  logic                    accept;
  logic                    s1_valid_q, s2_valid_q, out_valid_q;
  logic [31:0]             out_value_q;
  logic signed [SumW-1:0]  sum_d;
  logic signed [ProdW-1:0] prod [LANES];
  logic [CNT_W-1:0]        cnt_q;

  // A full output stage blocks the whole pipe until it transfers.
  assign en     = !out_valid_q || bus.out_ready;
  assign accept = bus.in_valid && en;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    cfu_mac_lane #(
      .OffW(OFF_W)
    ) u_lane (
      .clk    (clk),
      .reset_n(reset_n),
      .en     (en),
      .act    (lane_byte(bus.in_data, i)),
      .filt   (lane_byte(bus.in_filter, i)),
      .offset (bus.in_offset[OFF_W-1:0]),
      .prod   (prod[i])
    );
  end

  // Reduce lane products at full precision.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_d = sum_d + SumW'(prod[i]);
    end
  end

  // Valid shift chain and sign-extended result register; bubbles move when enabled.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
    end else if (en) begin
      s1_valid_q  <= accept;
      s2_valid_q  <= s1_valid_q;
      out_valid_q <= s2_valid_q;
      out_value_q <= 32'(sum_d);
    end
  end

  // Transfer counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (bus.cnt_clear) begin
      cnt_q <= '0;
    end else if (out_valid_q && bus.out_ready) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.in_ready    = en;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_value   = out_value_q;
  assign bus.out_add_acc = out_valid_q && bus.out_ready;
  assign bus.beat_count  = cnt_q;

endmodule

// File: tb/tb_cfu_simd_mac.sv
// Self-checking bench for cfu_simd_mac: behavioural model plus directed literal checks.
module tb_cfu_simd_mac;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  cfu_simd_mac_if #(.CNT_W(16)) bus ();

  cfu_simd_mac #(
    .LANES(4),
    .OFF_W(9),
    .CNT_W(16)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference dot product straight from the arithmetic definition.
  function automatic int dot(input logic [31:0] d, input logic [31:0] f, input logic [31:0] o);
    logic signed [8:0] os;
    logic signed [7:0] db, fb;
    int s;
    os = o[8:0];
    s  = 0;
    for (int i = 0; i < 4; i++) begin
      db = d[8*i +: 8];
      fb = f[8*i +: 8];
      s  = s + (int'(db) + int'(os)) * int'(fb);
    end
    return s;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Model: three in-flight slots, each holding a valid flag and its expected result.
  bit          m_v   [3];
  int          m_val [3];
  logic [15:0] m_cnt;
  bit          chk_on = 0;
  logic [31:0] dut_xfer [$];

  always @(posedge clk) begin
    bit adv;
    if (!reset_n) begin
      m_v   = '{0, 0, 0};
      m_cnt = '0;
    end else begin
      adv = !m_v[2] || bus.out_ready;
      if (bus.cnt_clear) m_cnt = '0;
      else if (m_v[2] && bus.out_ready) m_cnt = m_cnt + 16'd1;
      if (adv) begin
        m_v[2]   = m_v[1];
        m_val[2] = m_val[1];
        m_v[1]   = m_v[0];
        m_val[1] = m_val[0];
        m_v[0]   = bus.in_valid;
        m_val[0] = dot(bus.in_data, bus.in_filter, bus.in_offset);
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("in_ready", 32'(bus.in_ready), 32'(!m_v[2] || bus.out_ready));
      check("out_valid", 32'(bus.out_valid), 32'(m_v[2]));
      if (m_v[2]) check("out_value", bus.out_value, m_val[2]);
      check("out_add_acc", 32'(bus.out_add_acc), 32'(m_v[2] && bus.out_ready));
      check("beat_count", 32'(bus.beat_count), 32'(m_cnt));
      if (bus.out_valid && bus.out_ready) dut_xfer.push_back(bus.out_value);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input logic [31:0] d, input logic [31:0] f, input logic [31:0] o);
    bit acc;
    bit got;
    got           = 0;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_filter = f;
    bus.in_offset = o;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      acc = bus.in_ready;
      tick();
      got = acc;
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got no acceptance expected in_ready within 50 cycles");
    end
    bus.in_valid = 1'b0;
  endtask

  // Single beat with literal expectation and exact 3-cycle latency.
  task automatic directed(input string nm, input logic [31:0] d, input logic [31:0] f,
                          input logic [31:0] o, input logic [31:0] exp);
    logic [15:0] c0;
    check({"model_", nm}, dot(d, f, o), exp);
    c0 = m_cnt;
    send(d, f, o);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check({nm, "_valid_lat"}, 32'(bus.out_valid), 32'(k == 3));
      if (k == 3) begin
        check({nm, "_value"}, bus.out_value, exp);
        check({nm, "_add_acc"}, 32'(bus.out_add_acc), 32'd1);
      end
    end
    tick();
    @(negedge clk);
    check({nm, "_count"}, 32'(bus.beat_count), 32'(c0 + 16'd1));
    tick();
  endtask

  logic [31:0] bd [5], bf [5], bo [5];
  int          bexp [5];
  int          idx, stalled, acc_n;
  logic [15:0] c0;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_filter = '0;
    bus.in_offset = '0;
    bus.out_ready = 1'b1;
    bus.cnt_clear = 1'b0;
    reset_n       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk_on  = 1;

    // Reset state.
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_add_acc", 32'(bus.out_add_acc), 32'd0);
    check("rst_out_value", bus.out_value, 32'd0);
    check("rst_count", 32'(bus.beat_count), 32'd0);
    tick();

    directed("basic", 32'h7F80FF01, 32'hFF040302, 32'd128, 32'd384);
    directed("worst", 32'h7F7F7F7F, 32'h80808080, 32'd255, 32'hFFFD0400);
    directed("offtrunc", 32'h00000080, 32'h00000001, 32'h00000180, 32'hFFFFFF00);

    // Backpressure: five back-to-back beats, out_ready low in cycles 3..7.
    for (int i = 0; i < 5; i++) begin
      bd[i]   = $urandom;
      bf[i]   = $urandom;
      bo[i]   = $urandom;
      bexp[i] = dot(bd[i], bf[i], bo[i]);
    end
    dut_xfer.delete();
    c0      = m_cnt;
    idx     = 0;
    stalled = 0;
    for (int c = 0; c < 40 && dut_xfer.size() < 5; c++) begin
      bus.out_ready = !(c >= 3 && c <= 7);
      if (idx < 5) begin
        bus.in_valid  = 1'b1;
        bus.in_data   = bd[idx];
        bus.in_filter = bf[idx];
        bus.in_offset = bo[idx];
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (bus.out_valid && !bus.out_ready) begin
        check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        stalled++;
      end
      if (bus.in_valid && bus.in_ready) idx++;
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("bp_stall_cycles", 32'(stalled), 32'd5);
    check("bp_xfer_count", 32'(dut_xfer.size()), 32'd5);
    for (int i = 0; i < 5 && i < dut_xfer.size(); i++) check("bp_order", dut_xfer[i], bexp[i]);
    @(negedge clk);
    check("bp_beat_count", 32'(bus.beat_count), 32'(c0 + 16'd5));
    tick();

    // Reset one cycle before the first of two results.
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h01020304;
    bus.in_filter = 32'h05060708;
    bus.in_offset = 32'd3;
    tick();
    bus.in_data = 32'h11223344;
    tick();
    bus.in_valid = 1'b0;
    reset_n      = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_mid_count", 32'(bus.beat_count), 32'd0);
      check("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
    end

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = $urandom_range(0, 1);
      bus.in_data   = $urandom;
      bus.in_filter = $urandom;
      bus.in_offset = $urandom;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.cnt_clear = ($urandom_range(0, 31) == 0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.cnt_clear = 1'b0;
    repeat (4) tick();

    // Counter wrap: 65535 transfers, then one more.
    bus.cnt_clear = 1'b1;
    tick();
    bus.cnt_clear = 1'b0;
    acc_n         = 0;
    bus.in_valid  = 1'b1;
    for (int c = 0; c < 70000 && acc_n < 65535; c++) begin
      bus.in_data   = $urandom;
      bus.in_filter = $urandom;
      bus.in_offset = $urandom;
      @(negedge clk);
      if (bus.in_ready) acc_n++;
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    check("wrap_pre", 32'(bus.beat_count), 32'd65535);
    tick();
    send(32'h01010101, 32'h01010101, 32'd0);
    repeat (3) tick();
    @(negedge clk);
    check("wrap_zero", 32'(bus.beat_count), 32'd0);
    tick();

    // Clear coinciding with a transfer.
    send(32'h02020202, 32'h03030303, 32'd1);
    repeat (3) tick();
    @(negedge clk);
    check("clr_pre_one", 32'(bus.beat_count), 32'd1);
    tick();
    send(32'h04040404, 32'h05050505, 32'd2);
    tick();
    tick();
    bus.cnt_clear = 1'b1;
    tick();
    bus.cnt_clear = 1'b0;
    @(negedge clk);
    check("clr_priority", 32'(bus.beat_count), 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
